mul_flag_unit: RTL

- Iterative multi-cycle multiplier for MUL/MLA.
- Produces the flag-write side of the CPSR interface: drives ALUFlags and FlagWrite in the same encoding the conditional unit consumes.
  - ALUFlags[3:2] = {C,V}, ALUFlags[1:0] = {N,Z}.
  - FlagWrite[1] enables the C/V write; FlagWrite[0] enables the N/Z write.
- Sits in the execute stage beside the ALU. Asserts busy so hazard logic stalls the pipeline while a multiply is in flight.

---
 rtl/mul_flag_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/mul_flag_unit.sv
// Iterative shift-add multiplier for MUL/MLA with CPSR flag-write outputs.
// Fixed WIDTH-cycle latency; busy stalls the pipeline while a multiply is in flight.
module mul_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             CondEx,
  input  logic             Accumulate,
  input  logic             S,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic [WIDTH-1:0] Src_Acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic [1:0]       FlagWrite
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    counter;
  logic             s_q;
  logic             acc_start;

  always_comb begin
    acc_start = start & CondEx;
    acc_next  = mplier[0] ? acc + mcand : acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      counter <= '0;
      s_q     <= 1'b0;
      Result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back issue.
        IDLE, DONE: begin
          done <= 1'b0;
          if (acc_start) begin
            mcand   <= Src_A;
            mplier  <= Src_B;
            acc     <= Accumulate ? Src_Acc : '0;
            s_q     <= S;
            counter <= '0;
            state   <= RUN;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CW'(1);
          if (counter == LAST) begin
            Result <= acc_next;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // C and V are never written by a multiply, so they stay zero.
  always_comb begin
    ALUFlags  = 4'b0000;
    FlagWrite = 2'b00;
    if (done) begin
      ALUFlags  = {2'b00, Result[WIDTH-1], (Result == '0)};
      FlagWrite = {1'b0, s_q};
    end
  end

endmodule
